// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types and helpers for the I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_e;

  // A frame is one left slot followed by one right slot.
  function automatic int frame_len(input int slot_width);
    return 2 * slot_width;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample/serial bundle between the sine/cosine generator, the
// transmitter and the DAC pins.
interface i2s_tx_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  sample_req;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;

  // Transmitter side.
  modport master (
    input  enable, left_data, right_data,
    output sample_req, bclk, lrclk, sdata
  );

  // Generator/DAC side.
  modport slave (
    output enable, left_data, right_data,
    input  sample_req, bclk, lrclk, sdata
  );
endinterface

// File: rtl/i2s_tx_serializer_bclk_div.sv
// Bit-clock divider: bclk toggles every BCLK_HALF clk cycles while not
// cleared, and flags the cycle in which each edge is registered.
module i2s_bclk_div
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic clear_i,
  output logic bclk_o,
  output logic rise_evt_o,
  output logic fall_evt_o
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             half_end;

  assign half_end = (div_cnt_q == DIV_W'(BCLK_HALF - 1));

  // Next divider count and bclk level.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (clear_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (half_end) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (arst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Strobes are high in the cycle whose closing edge moves bclk.
  assign rise_evt_o = !clear_i && half_end && !bclk_q;
  assign fall_evt_o = !clear_i && half_end &&  bclk_q;
  assign bclk_o     = bclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-I2S transmitter: pulls one stereo pair per frame from the
// generator and shifts it out MSB first with one bclk of delay after
// each lrclk edge.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 2
) (
  input  logic                clk,
  input  logic                arst,
  i2s_tx_serializer_if.master tx_if
);

  localparam int FRAME_LEN = frame_len(SLOT_WIDTH);
  localparam int BIT_W     = $clog2(FRAME_LEN);

  i2s_state_e           state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [FRAME_LEN-1:0] shift_q, shift_d, frame_word;
  logic                 sdata_q, sdata_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sample_req_q, sample_req_d;
  logic                 bclk, fall_evt, wrap;
  // Bits only change on falling bclk, so the rise strobe has no consumer.
  logic                 rise_evt_unused;

  i2s_bclk_div #(
    .BCLK_HALF (BCLK_HALF)
  ) u_div (
    .clk        (clk),
    .arst       (arst),
    .clear_i    (state_q == IDLE),
    .bclk_o     (bclk),
    .rise_evt_o (rise_evt_unused),
    .fall_evt_o (fall_evt)
  );

  // Left-justified, zero-padded frame from the words presented right now.
  always_comb begin
    frame_word = '0;
    frame_word[FRAME_LEN-1  -: DATA_WIDTH] = tx_if.left_data;
    frame_word[SLOT_WIDTH-1 -: DATA_WIDTH] = tx_if.right_data;
  end

  assign bit_nxt = (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
  assign wrap    = fall_evt && (bit_nxt == BIT_W'(1));

  // Next state, bit position, shift register and output levels.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sdata_d      = sdata_q;
    lrclk_d      = lrclk_q;
    sample_req_d = 1'b0;

    case (state_q)
      IDLE:    if (tx_if.enable) state_d = RUN;
      RUN:     if (!tx_if.enable) state_d = DRAIN;
      DRAIN: begin
        if (tx_if.enable) state_d = RUN;
        else if (wrap)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fall_evt) begin
      if (state_q == DRAIN && !tx_if.enable && wrap) begin
        // Right LSB has had its full bclk: park the line without a new load.
        bit_cnt_d = '0;
        shift_d   = '0;
        sdata_d   = 1'b0;
        lrclk_d   = 1'b0;
      end else begin
        bit_cnt_d = bit_nxt;
        lrclk_d   = (bit_nxt >= BIT_W'(SLOT_WIDTH));
        if (wrap) begin
          shift_d      = frame_word;
          sdata_d      = frame_word[FRAME_LEN-1];
          sample_req_d = 1'b1;
        end else begin
          shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
          sdata_d = shift_q[FRAME_LEN-2];
        end
      end
    end
  end

  // Serializer state register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sdata_q      <= 1'b0;
      lrclk_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sdata_q      <= sdata_d;
      lrclk_q      <= lrclk_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign tx_if.sample_req = sample_req_q;
  assign tx_if.bclk       = bclk;
  assign tx_if.lrclk      = lrclk_q;
  assign tx_if.sdata      = sdata_q;

endmodule
